// File: rtl/temp_display_if.sv
// Signal bundle between the temperature display feeder and its neighbours:
// buttons and temperature sample in, display value/blank and setpoint out.
interface temp_display_if;
  // temp_valid is a one-cycle strobe qualifying temp_in. There is no ready:
  // the feeder accepts a sample on every cycle that temp_valid is high.
  logic       btn_up;
  logic       btn_dn;
  logic [7:0] temp_in;
  logic       temp_valid;
  logic [7:0] disp_num;
  logic       disp_blank;
  logic [7:0] setpoint;
  logic       edit_mode;
  logic       dbg_state;

  modport master (
    output btn_up, btn_dn, temp_in, temp_valid,
    input  disp_num, disp_blank, setpoint, edit_mode, dbg_state
  );

  modport slave (
    input  btn_up, btn_dn, temp_in, temp_valid,
    output disp_num, disp_blank, setpoint, edit_mode, dbg_state
  );
endinterface

// File: rtl/temp_display_ctrl.sv
// Setpoint editor and display source selector for the two-digit seven-segment
// driver: shows measured temperature, or the blinking setpoint while editing.
module temp_display_ctrl #(
  parameter int SP_DEFAULT   = 25,
  parameter int SP_MIN       = 5,
  parameter int SP_MAX       = 40,
  parameter int BLINK_CYC    = 12500000,
  parameter int EDIT_TIMEOUT = 125000000
) (
  input  logic           clk,
  input  logic           rst,
  temp_display_if.slave  bus_if
);

  localparam int TW = (EDIT_TIMEOUT > 1) ? $clog2(EDIT_TIMEOUT) : 1;
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(EDIT_TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  typedef enum logic {
    SHOW_TEMP = 1'b0,
    EDIT      = 1'b1
  } state_e;

  logic          up_s1_q, up_s2_q, up_prev_q;
  logic          dn_s1_q, dn_s2_q, dn_prev_q;
  logic [7:0]    temp_q;
  logic          seen_q;
  logic [7:0]    sp_q;
  state_e        state_q;
  logic [TW-1:0] tmo_q;
  logic [BW-1:0] blink_q;
  logic          hidden_q;
  logic [7:0]    disp_num_q;
  logic          disp_blank_q;
  logic          edit_q;

  logic          up_press, dn_press, one_press;
  logic [7:0]    sp_up_d, sp_dn_d, temp_d;

  always_comb begin
    up_press  = up_s2_q & ~up_prev_q;
    dn_press  = dn_s2_q & ~dn_prev_q;
    // Both buttons rising together is ambiguous and is treated as no press.
    one_press = up_press ^ dn_press;
    sp_up_d   = (sp_q >= 8'(SP_MAX)) ? 8'(SP_MAX) : sp_q + 8'd1;
    sp_dn_d   = (sp_q <= 8'(SP_MIN)) ? 8'(SP_MIN) : sp_q - 8'd1;
    temp_d    = (bus_if.temp_in > 8'd99) ? 8'd99 : bus_if.temp_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_s1_q   <= 1'b0;
      up_s2_q   <= 1'b0;
      up_prev_q <= 1'b0;
      dn_s1_q   <= 1'b0;
      dn_s2_q   <= 1'b0;
      dn_prev_q <= 1'b0;
      temp_q    <= 8'd0;
      seen_q    <= 1'b0;
    end else begin
      up_s1_q   <= bus_if.btn_up;
      up_s2_q   <= up_s1_q;
      up_prev_q <= up_s2_q;
      dn_s1_q   <= bus_if.btn_dn;
      dn_s2_q   <= dn_s1_q;
      dn_prev_q <= dn_s2_q;
      if (bus_if.temp_valid) begin
        temp_q <= temp_d;
        seen_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SHOW_TEMP;
      sp_q         <= 8'(SP_DEFAULT);
      tmo_q        <= '0;
      blink_q      <= '0;
      hidden_q     <= 1'b0;
      disp_num_q   <= 8'd0;
      disp_blank_q <= 1'b1;
      edit_q       <= 1'b0;
    end else begin
      case (state_q)
        SHOW_TEMP: begin
          tmo_q    <= '0;
          blink_q  <= '0;
          hidden_q <= 1'b0;
          if (one_press) state_q <= EDIT;
        end
        EDIT: begin
          if (one_press) begin
            sp_q     <= up_press ? sp_up_d : sp_dn_d;
            tmo_q    <= '0;
            blink_q  <= '0;
            hidden_q <= 1'b0;
          end else if (tmo_q == TMO_LAST) begin
            state_q  <= SHOW_TEMP;
            tmo_q    <= '0;
            blink_q  <= '0;
            hidden_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (blink_q == BLINK_LAST) begin
              blink_q  <= '0;
              hidden_q <= ~hidden_q;
            end else begin
              blink_q <= blink_q + 1'b1;
            end
          end
        end
      endcase
      // Display outputs trail the state/setpoint/temp registers by one clock.
      disp_num_q   <= (state_q == EDIT) ? sp_q : temp_q;
      disp_blank_q <= (state_q == EDIT) ? hidden_q : ~seen_q;
      edit_q       <= (state_q == EDIT);
    end
  end

  assign bus_if.disp_num   = disp_num_q;
  assign bus_if.disp_blank = disp_blank_q;
  assign bus_if.setpoint   = sp_q;
  assign bus_if.edit_mode  = edit_q;
  assign bus_if.dbg_state  = state_q;

endmodule

// File: tb/tb_temp_display_ctrl.sv
// Self-checking bench for temp_display_ctrl with short blink/timeout periods.
module tb_temp_display_ctrl;

  localparam int BLINK  = 4;
  localparam int TMO    = 20;
  localparam int SP_MIN = 5;
  localparam int SP_MAX = 40;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_sp;
  int   last_temp;
  logic [7:0] exp_q[$];

  temp_display_if bus ();

  temp_display_ctrl #(
    .SP_DEFAULT  (25),
    .SP_MIN      (SP_MIN),
    .SP_MAX      (SP_MAX),
    .BLINK_CYC   (BLINK),
    .EDIT_TIMEOUT(TMO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_if(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: strobe one temperature sample, check it reaches the display
  task automatic pulse_temp(input int v);
    logic [7:0] got;
    bus.temp_in    = 8'(v);
    bus.temp_valid = 1'b1;
    exp_q.push_back((v > 99) ? 8'd99 : 8'(v));
    last_temp = (v > 99) ? 99 : v;
    wait_neg(1);
    bus.temp_valid = 1'b0;
    wait_neg(1);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL temp_scoreboard_empty");
    end else begin
      got = exp_q.pop_front();
      if (bus.disp_num !== got || bus.disp_blank !== 1'b0) begin
        bad++;
        $display("FAIL temp_disp in=%0d: num=%0d blank=%b, want num=%0d blank=0",
                 v, bus.disp_num, bus.disp_blank, got);
      end
    end
  endtask

  // driver: one press; in_edit applies the saturating model step
  task automatic press(input bit up, input bit in_edit);
    logic [7:0] want;
    if (up) bus.btn_up = 1'b1;
    else    bus.btn_dn = 1'b1;
    if (in_edit) begin
      if (up) exp_sp = (exp_sp + 1 > SP_MAX) ? SP_MAX : exp_sp + 1;
      else    exp_sp = (exp_sp - 1 < SP_MIN) ? SP_MIN : exp_sp - 1;
    end
    exp_q.push_back(8'(exp_sp));
    wait_neg(3);
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL press_scoreboard_empty");
    end else begin
      want = exp_q.pop_front();
      if (bus.setpoint !== want) begin
        bad++;
        $display("FAIL press_setpoint up=%b: got=%0d want=%0d", up, bus.setpoint, want);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_neg(3);
    total++;
    if (bus.disp_blank !== 1'b1 || bus.disp_num !== 8'd0 ||
        bus.setpoint !== 8'd25 || bus.edit_mode !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: blank=%b num=%0d sp=%0d edit=%b, want 1/0/25/0",
               bus.disp_blank, bus.disp_num, bus.setpoint, bus.edit_mode);
    end
    rst = 1'b0;
    wait_neg(3);
    total++;
    if (bus.disp_blank !== 1'b1 || bus.disp_num !== 8'd0 || bus.edit_mode !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: blank=%b num=%0d edit=%b, want 1/0/0",
               bus.disp_blank, bus.disp_num, bus.edit_mode);
    end
  endtask

  task automatic test_show_temp;
    pulse_temp(23);
    pulse_temp(0);
    pulse_temp($urandom_range(1, 98));
  endtask

  task automatic test_clamp;
    int vals[4] = '{150, 99, 100, 255};
    for (int i = 0; i < 4; i++) pulse_temp(vals[i]);
    // a changing temp_in without a strobe must not reach the display
    bus.temp_in = 8'd77;
    wait_neg(4);
    total++;
    if (bus.disp_num !== 8'(last_temp)) begin
      bad++;
      $display("FAIL no_strobe_hold: num=%0d want=%0d", bus.disp_num, last_temp);
    end
  endtask

  task automatic test_edit_adjust;
    press(1'b1, 1'b0);
    wait_neg(1);
    total++;
    if (bus.edit_mode !== 1'b1 || bus.disp_num !== 8'd25 || bus.disp_blank !== 1'b0) begin
      bad++;
      $display("FAIL edit_enter: edit=%b num=%0d blank=%b, want 1/25/0",
               bus.edit_mode, bus.disp_num, bus.disp_blank);
    end
    wait_neg(1);
    press(1'b1, 1'b1);
    wait_neg(2);
    press(1'b1, 1'b1);
    for (int i = 1; i <= TMO + 1; i++) begin
      wait_neg(1);
      total++;
      if (i <= TMO) begin
        if (bus.edit_mode !== 1'b1 || bus.disp_num !== 8'd27 ||
            bus.disp_blank !== 1'(((i - 1) / BLINK) % 2)) begin
          bad++;
          $display("FAIL blink_cycle%0d: edit=%b num=%0d blank=%b, want 1/27/%0d",
                   i, bus.edit_mode, bus.disp_num, bus.disp_blank, ((i - 1) / BLINK) % 2);
        end
      end else begin
        if (bus.edit_mode !== 1'b0 || bus.disp_num !== 8'(last_temp) ||
            bus.disp_blank !== 1'b0) begin
          bad++;
          $display("FAIL edit_timeout: edit=%b num=%0d blank=%b, want 0/%0d/0",
                   bus.edit_mode, bus.disp_num, bus.disp_blank, last_temp);
        end
      end
    end
  endtask

  task automatic test_saturation;
    press(1'b1, 1'b0);
    for (int n = 0; n < 60; n++) begin
      wait_neg(2);
      press(n < 20, 1'b1);
      wait_neg(1);
      total++;
      if (bus.disp_blank !== 1'b0 || bus.edit_mode !== 1'b1) begin
        bad++;
        $display("FAIL sat_restart press%0d: blank=%b edit=%b, want 0/1",
                 n, bus.disp_blank, bus.edit_mode);
      end
    end
    wait_neg(TMO + 5);
    total++;
    if (bus.edit_mode !== 1'b0 || bus.setpoint !== 8'(SP_MIN)) begin
      bad++;
      $display("FAIL sat_end: edit=%b sp=%0d, want 0/%0d", bus.edit_mode, bus.setpoint, SP_MIN);
    end
  endtask

  task automatic test_simultaneous;
    press(1'b1, 1'b0);
    wait_neg(2);
    bus.btn_up = 1'b1;
    bus.btn_dn = 1'b1;
    wait_neg(18);
    total++;
    if (bus.edit_mode !== 1'b1 || bus.setpoint !== 8'(exp_sp)) begin
      bad++;
      $display("FAIL simul_before_tmo: edit=%b sp=%0d, want 1/%0d",
               bus.edit_mode, bus.setpoint, exp_sp);
    end
    wait_neg(1);
    total++;
    if (bus.edit_mode !== 1'b0 || bus.setpoint !== 8'(exp_sp)) begin
      bad++;
      $display("FAIL simul_tmo: edit=%b sp=%0d, want 0/%0d",
               bus.edit_mode, bus.setpoint, exp_sp);
    end
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;
    wait_neg(4);
  endtask

  task automatic test_held;
    logic [7:0] want;
    press(1'b0, 1'b0);
    wait_neg(2);
    bus.btn_up = 1'b1;
    exp_sp = exp_sp + 1;
    exp_q.push_back(8'(exp_sp));
    wait_neg(12);
    want = exp_q.pop_front();
    total++;
    if (bus.setpoint !== want) begin
      bad++;
      $display("FAIL held_one_step: sp=%0d want=%0d", bus.setpoint, want);
    end
    bus.btn_up = 1'b0;
    wait_neg(TMO + 5);
    total++;
    if (bus.edit_mode !== 1'b0) begin
      bad++;
      $display("FAIL held_tmo: edit=%b want 0", bus.edit_mode);
    end
  endtask

  task automatic test_reset_mid_edit;
    press(1'b1, 1'b0);
    while (exp_sp < 30) begin
      wait_neg(2);
      press(1'b1, 1'b1);
    end
    wait_neg(1);
    total++;
    if (bus.edit_mode !== 1'b1 || bus.disp_num !== 8'd30) begin
      bad++;
      $display("FAIL pre_reset_edit: edit=%b num=%0d, want 1/30", bus.edit_mode, bus.disp_num);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.setpoint !== 8'd25 || bus.disp_blank !== 1'b1 ||
        bus.edit_mode !== 1'b0 || bus.disp_num !== 8'd0) begin
      bad++;
      $display("FAIL async_reset: sp=%0d blank=%b edit=%b num=%0d, want 25/1/0/0",
               bus.setpoint, bus.disp_blank, bus.edit_mode, bus.disp_num);
    end
    wait_neg(1);
    rst = 1'b0;
    exp_sp = 25;
    wait_neg(3);
    total++;
    if (bus.setpoint !== 8'(exp_sp) || bus.disp_blank !== 1'b1 || bus.edit_mode !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_release: sp=%0d blank=%b edit=%b, want 25/1/0",
               bus.setpoint, bus.disp_blank, bus.edit_mode);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    exp_sp         = 25;
    last_temp      = 0;
    rst            = 1'b1;
    bus.btn_up     = 1'b0;
    bus.btn_dn     = 1'b0;
    bus.temp_in    = 8'd0;
    bus.temp_valid = 1'b0;
    test_reset();
    test_show_temp();
    test_clamp();
    test_edit_adjust();
    test_saturation();
    test_simultaneous();
    test_held();
    test_reset_mid_edit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
